audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_dac_serializer_if.sv | 25 ++
 rtl/edge_sync.sv | 35 +++
 rtl/audio_dac_serializer.sv | 136 +++++++++++++
 tb/tb_audio_dac_serializer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC serializer.
package audio_pkg;

  // Depth of the metastability synchronizer ahead of the edge-detect flop
  localparam int unsigned SYNC_STAGES = 2;

  // Channel-slot serializer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BCLK = 2'd1,
    SHIFT     = 2'd2,
    PAD       = 2'd3
  } ser_state_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample producer -> serializer handshake bus (one left/right pair per transfer).
interface audio_dac_serializer_if #(
  parameter int unsigned WORD_LENGTH = 16
) ();

  logic [WORD_LENGTH-1:0] left_data;
  logic [WORD_LENGTH-1:0] right_data;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (
    output left_data,
    output right_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into clk and flags its rising/falling edges.
module edge_sync
  import audio_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   level;

  assign level = sync[SYNC_STAGES-1];

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= level;
    end
  end

  // Single-cycle edge pulses
  always_comb begin
    rise_c = level & ~prev;
    fall_c = ~level & prev;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers one stereo pair and shifts it out MSB first on bclk.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  audio_dac_serializer_if.slave bus,
  input  logic                 bclk,
  input  logic                 daclrck,
  output logic                 dacdat,
  output logic                 underrun
);

  localparam int unsigned CNT_W = $clog2(WORD_LENGTH + 1);

  logic                   bclk_fall_c;
  logic                   bclk_rise_unused;
  logic                   lr_rise_c;
  logic                   lr_fall_c;

  logic [WORD_LENGTH-1:0] hold_l;
  logic [WORD_LENGTH-1:0] hold_r;
  logic                   hold_full;
  logic                   ready_q;
  logic [WORD_LENGTH-1:0] frame_l;
  logic [WORD_LENGTH-1:0] frame_r;
  logic [WORD_LENGTH-1:0] shift_reg;
  logic [CNT_W-1:0]       bit_cnt;
  ser_state_t             state;

  logic                   accept_c;
  logic                   hold_full_next_c;
  logic [WORD_LENGTH-1:0] left_next_c;
  logic [WORD_LENGTH-1:0] right_next_c;

  edge_sync u_bclk_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (bclk),
    .rise_c (bclk_rise_unused),
    .fall_c (bclk_fall_c)
  );

  edge_sync u_lr_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (daclrck),
    .rise_c (lr_rise_c),
    .fall_c (lr_fall_c)
  );

  assign bus.sample_ready = ready_q;

  // Handshake acceptance and the word that a left-channel start would latch
  always_comb begin
    accept_c         = bus.sample_valid & ~hold_full;
    hold_full_next_c = accept_c | (hold_full & ~lr_fall_c);
    left_next_c      = hold_full ? hold_l : '0;
    right_next_c     = hold_full ? hold_r : '0;
  end

  // Holding buffer and frame latch; a frame start never refills the buffer in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
      frame_l   <= '0;
      frame_r   <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun  <= lr_fall_c & ~hold_full;
      if (accept_c) begin
        hold_l <= bus.left_data;
        hold_r <= bus.right_data;
      end
      if (lr_fall_c) begin
        frame_l <= left_next_c;
        frame_r <= right_next_c;
      end
      hold_full <= hold_full_next_c;
      ready_q   <= ~hold_full_next_c;
    end
  end

  // Slot serializer: restart on every LR edge, one-bit I2S delay, then MSB-first, then pad
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dacdat    <= 1'b0;
    end else if (lr_rise_c || lr_fall_c) begin
      state     <= WAIT_BCLK;
      shift_reg <= lr_fall_c ? left_next_c : frame_r;
      bit_cnt   <= '0;
      dacdat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dacdat <= 1'b0;
        end
        WAIT_BCLK: begin
          if (bclk_fall_c) begin
            dacdat    <= shift_reg[WORD_LENGTH-1];
            shift_reg <= {shift_reg[WORD_LENGTH-2:0], 1'b0};
            bit_cnt   <= CNT_W'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bclk_fall_c) begin
            if (bit_cnt < CNT_W'(WORD_LENGTH)) begin
              dacdat    <= shift_reg[WORD_LENGTH-1];
              shift_reg <= {shift_reg[WORD_LENGTH-2:0], 1'b0};
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end else begin
              dacdat <= 1'b0;
              state  <= PAD;
            end
          end
        end
        PAD: begin
          dacdat <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench: stereo pairs are pushed through the handshake and the serial
// stream is compared, bclk by bclk, against a slot-level model of the I2S framing.
module tb_audio_dac_serializer;

  localparam int WL = 16;

  logic clk;
  logic reset;
  logic bclk;
  logic daclrck;
  logic dacdat;
  logic underrun;

  audio_dac_serializer_if #(.WORD_LENGTH(WL)) bus ();

  audio_dac_serializer #(.WORD_LENGTH(WL)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .bclk     (bclk),
    .daclrck  (daclrck),
    .dacdat   (dacdat),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one-deep holding buffer and the words of the current frame
  logic          m_full;
  logic [WL-1:0] m_l, m_r;
  logic [WL-1:0] cur_l, cur_r;
  logic [WL-1:0] pend_l, pend_r;
  logic          last_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one pair and wait (bounded) until the handshake completes
  task automatic offer(input logic [WL-1:0] l, input logic [WL-1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    bus.left_data    = l;
    bus.right_data   = r;
    bus.sample_valid = 1'b1;
    while (bus.sample_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_accepted_in_time", 32'(n < 200), 32'd1);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    m_full = 1'b1;
    m_l    = l;
    m_r    = r;
  endtask

  // One channel slot of nbclk bit clocks; the first falling bclk coincides with the LR edge
  task automatic run_slot(input logic lr, input int nbclk, input bit watch);
    logic [WL-1:0] word;
    logic          exp_bit;
    logic          exp_un;
    exp_un = 1'b0;
    for (int k = 0; k < nbclk; k++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (k == 0) begin
        daclrck = lr;
        if (!lr) begin
          if (m_full) begin
            cur_l  = m_l;
            cur_r  = m_r;
            m_full = 1'b0;
            exp_un = 1'b0;
          end else begin
            cur_l  = '0;
            cur_r  = '0;
            exp_un = 1'b1;
          end
        end
      end
      word    = lr ? cur_r : cur_l;
      exp_bit = (k == 0 || k > WL) ? 1'b0 : word[WL-k];
      @(negedge clk);
      @(negedge clk);
      check("dacdat_before_latency", 32'(dacdat), 32'(last_bit));
      if (k == 0 && watch) check("ready_before_transfer", 32'(bus.sample_ready), 32'd0);
      @(negedge clk);
      check(lr ? "dacdat_right_bit" : "dacdat_left_bit", 32'(dacdat), 32'(exp_bit));
      if (k == 0 && !lr) check("underrun_pulse", 32'(underrun), 32'(exp_un));
      if (k == 0 && watch) check("ready_after_transfer", 32'(bus.sample_ready), 32'd1);
      @(negedge clk);
      if (k == 0 && !lr) check("underrun_one_cycle", 32'(underrun), 32'd0);
      if (k == 0 && watch) begin
        check("ready_after_refill", 32'(bus.sample_ready), 32'd0);
        bus.sample_valid = 1'b0;
        m_full = 1'b1;
        m_l    = pend_l;
        m_r    = pend_r;
      end
      last_bit = exp_bit;
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame(input int nl, input int nr);
    run_slot(1'b0, nl, 1'b0);
    run_slot(1'b1, nr, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bclk             = 1'b1;
    daclrck          = 1'b1;
    bus.left_data    = '0;
    bus.right_data   = '0;
    bus.sample_valid = 1'b0;
    m_full   = 1'b0;
    m_l      = '0;
    m_r      = '0;
    cur_l    = '0;
    cur_r    = '0;
    pend_l   = '0;
    pend_r   = '0;
    last_bit = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_dacdat", 32'(dacdat), 32'd0);
    check("reset_ready", 32'(bus.sample_ready), 32'd1);
    check("reset_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Nothing offered: underrun and silent slots
    frame(32, 32);

    // Known pattern with full-length slots
    offer(16'hA5C3, 16'h0F0F);
    frame(32, 32);

    // Buffer full: second pair waits for the frame start, then is taken the cycle after
    offer(16'($urandom), 16'($urandom));
    @(negedge clk);
    pend_l           = 16'($urandom);
    pend_r           = 16'($urandom);
    bus.left_data    = pend_l;
    bus.right_data   = pend_r;
    bus.sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_low_while_full", 32'(bus.sample_ready), 32'd0);
    run_slot(1'b0, 32, 1'b1);
    run_slot(1'b1, 32, 1'b0);
    frame(32, 32);

    // Short left slot truncates LSBs; right slot must start cleanly
    offer(16'hFFFF, 16'($urandom));
    frame(9, 32);

    // Random pairs with random slot lengths, some truncating
    for (int i = 0; i < 4; i++) begin
      offer(16'($urandom), 16'($urandom));
      frame(int'($urandom_range(10, 32)), int'($urandom_range(10, 32)));
    end

    // Reset in the middle of the left slot with a second pair held
    offer(16'hFFFF, 16'($urandom));
    run_slot(1'b0, 6, 1'b0);
    offer(16'($urandom), 16'($urandom));
    check("ready_low_before_reset", 32'(bus.sample_ready), 32'd0);
    check("dacdat_high_before_reset", 32'(dacdat), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midframe_reset_dacdat", 32'(dacdat), 32'd0);
    check("midframe_reset_ready", 32'(bus.sample_ready), 32'd1);
    check("midframe_reset_underrun", 32'(underrun), 32'd0);
    m_full   = 1'b0;
    cur_l    = '0;
    cur_r    = '0;
    last_bit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_slot(1'b1, 32, 1'b0);
    frame(32, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
